// File: rtl/otter_alu_mx_if.sv
// Handshake bundle between the control unit (master) and the execute-stage ALU (slave).
interface otter_alu_mx_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output in_valid, op, srcA, srcB, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, srcA, srcB, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/otter_alu_mx.sv
// Handshaked OTTER ALU: single-cycle RV32I base ops, iterative RV32M mul/div/rem.
// One shared 2*WIDTH accumulator serves both the shift-add multiplier
// ({partial product, multiplier}) and the restoring divider ({remainder, quotient}).
module otter_alu_mx #(
  parameter int WIDTH = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            flush,
  otter_alu_mx_if.slave   bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;      // multiplicand magnitude or divisor magnitude
  logic [1:0]         op_sel;
  logic               neg_q;     // negate product / quotient at the end
  logic               neg_r;     // negate remainder at the end
  logic [WIDTH-1:0]   res;
  logic               res_valid;

  logic accept;

  assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
  assign bus.out_valid = res_valid;
  assign bus.result    = res;
  assign bus.busy      = (state == MUL) || (state == DIV);
  assign accept        = bus.in_valid && bus.in_ready && !flush;

  // Single-cycle base operation result from the live operands.
  logic [WIDTH-1:0] base_val;
  logic [SHW-1:0]   sh;
  assign sh = bus.srcB[SHW-1:0];
  always_comb begin
    base_val = WIDTH'(42);
    case (bus.op[3:0])
      4'b0000: base_val = bus.srcA + bus.srcB;
      4'b1000: base_val = bus.srcA - bus.srcB;
      4'b0110: base_val = bus.srcA | bus.srcB;
      4'b0111: base_val = bus.srcA & bus.srcB;
      4'b0100: base_val = bus.srcA ^ bus.srcB;
      4'b0101: base_val = bus.srcA >> sh;
      4'b0001: base_val = bus.srcA << sh;
      4'b1101: base_val = WIDTH'($signed(bus.srcA) >>> sh);
      4'b0010: base_val = {{(WIDTH-1){1'b0}}, ($signed(bus.srcA) < $signed(bus.srcB))};
      4'b0011: base_val = {{(WIDTH-1){1'b0}}, (bus.srcA < bus.srcB)};
      4'b1001: base_val = bus.srcA;
      default: base_val = WIDTH'(42);
    endcase
  end

  // M-op setup: operand signedness, magnitudes and the divide special cases.
  logic             is_div, sgn_en_a, sgn_en_b, sa, sb, fast;
  logic [WIDTH-1:0] mag_a, mag_b, fast_val;
  always_comb begin
    is_div   = bus.op[2];
    sgn_en_a = is_div ? !bus.op[0] : (bus.op[1] ^ bus.op[0]);
    sgn_en_b = is_div ? !bus.op[0] : (bus.op[1:0] == 2'b01);
    sa       = sgn_en_a && bus.srcA[WIDTH-1];
    sb       = sgn_en_b && bus.srcB[WIDTH-1];
    mag_a    = sa ? -bus.srcA : bus.srcA;
    mag_b    = sb ? -bus.srcB : bus.srcB;
    fast     = 1'b0;
    fast_val = '0;
    if (is_div && bus.srcB == '0) begin
      fast     = 1'b1;
      fast_val = bus.op[1] ? bus.srcA : ONES;
    end else if (is_div && !bus.op[0] && bus.srcA == MIN && bus.srcB == ONES) begin
      fast     = 1'b1;
      fast_val = bus.op[1] ? '0 : MIN;
    end
  end

  // One iteration step of each engine plus the final sign fix-up.
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [2*WIDTH-1:0] mul_next, div_next, mul_prod;
  logic [WIDTH-1:0]   div_diff, div_rem, div_q, div_r, mul_res, div_res;
  logic               div_ge;
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    mul_prod  = neg_q ? -mul_next : mul_next;
    mul_res   = (op_sel == 2'b00) ? mul_prod[WIDTH-1:0] : mul_prod[2*WIDTH-1:WIDTH];
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
    div_next  = {div_rem, acc[WIDTH-2:0], div_ge};
    div_q     = div_next[WIDTH-1:0];
    div_r     = div_next[2*WIDTH-1:WIDTH];
    div_res   = op_sel[1] ? (neg_r ? -div_r : div_r) : (neg_q ? -div_q : div_q);
  end

  // Control FSM with the datapath registers it owns.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      op_sel    <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      res       <= '0;
      res_valid <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      res_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (!bus.op[4]) begin
              res       <= base_val;
              res_valid <= 1'b1;
              state     <= DONE;
            end else if (fast) begin
              res       <= fast_val;
              res_valid <= 1'b1;
              state     <= DONE;
            end else begin
              res_valid <= 1'b0;
              cnt       <= SHW'(WIDTH-1);
              op_sel    <= bus.op[1:0];
              neg_q     <= sa ^ sb;
              neg_r     <= sa;
              if (is_div) begin
                acc   <= {{WIDTH{1'b0}}, mag_a};
                opnd  <= mag_b;
                state <= DIV;
              end else begin
                acc   <= {{WIDTH{1'b0}}, mag_b};
                opnd  <= mag_a;
                state <= MUL;
              end
            end
          end else if (state == DONE && bus.out_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
          end
        end
        MUL: begin
          acc <= mul_next;
          if (cnt == '0) begin
            res       <= mul_res;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIV: begin
          acc <= div_next;
          if (cnt == '0) begin
            res       <= div_res;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_otter_alu_mx.sv
// Directed bench for otter_alu_mx at WIDTH=32 with hand-computed expectations.
module tb_otter_alu_mx;
  localparam int W = 32;

  localparam logic [4:0] ADD = 5'h00, SUB = 5'h08, OR_ = 5'h06, AND_ = 5'h07, XOR_ = 5'h04;
  localparam logic [4:0] SRL = 5'h05, SLL = 5'h01, SRA = 5'h0D, SLT = 5'h02, SLTU = 5'h03;
  localparam logic [4:0] LUI = 5'h09, BAD = 5'h0A;
  localparam logic [4:0] MUL = 5'h10, MULH = 5'h11, MULHSU = 5'h12, MULHU = 5'h13;
  localparam logic [4:0] DIV = 5'h14, DIVU = 5'h15, REM = 5'h16, REMU = 5'h17;

  logic CLK;
  logic RST_N;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  otter_alu_mx_if #(.WIDTH(W)) bus ();

  otter_alu_mx #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .flush (flush),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present one op at the negedge; returns just after the accepting edge.
  task automatic issue(input string tag, input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge CLK);
    bus.op = o; bus.srcA = a; bus.srcB = b; bus.in_valid = 1'b1;
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    bus.srcA = 32'hDEAD_BEEF; bus.srcB = 32'h0BAD_F00D;
  endtask

  // Issue an op and wait (bounded) for out_valid; checks value, edges after accept, busy cycles.
  task automatic run(input string tag, input logic [4:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_edges,
                     input int exp_busy);
    int edges = 0;
    int busy_n = 0;
    issue(tag, o, a, b);
    while (!bus.out_valid && edges < 200) begin
      if (bus.busy) busy_n++;
      step();
      edges++;
    end
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_result"}, 64'(bus.result), 64'(exp));
    check({tag, "_latency"}, 64'(edges), 64'(exp_edges));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
  endtask

  initial begin
    RST_N = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.op = '0; bus.srcA = '0; bus.srcB = '0;
    #12;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge CLK);
    RST_N = 1'b1;

    // Back-to-back: add then sra with out_ready held high.
    @(negedge CLK);
    bus.op = ADD; bus.srcA = 32'd5; bus.srcB = 32'd7; bus.in_valid = 1'b1;
    step();
    check("b2b_add", 64'(bus.result), 64'd12);
    check("b2b_add_valid", 64'(bus.out_valid), 64'd1);
    check("b2b_add_in_ready", 64'(bus.in_ready), 64'd1);
    bus.op = SRA; bus.srcA = 32'h8000_0000; bus.srcB = 32'd4;
    step();
    check("b2b_sra", 64'(bus.result), 64'hF800_0000);
    check("b2b_sra_valid", 64'(bus.out_valid), 64'd1);
    check("b2b_sra_in_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b0;
    step();
    check("b2b_drained", 64'(bus.out_valid), 64'd0);
    check("b2b_result_held", 64'(bus.result), 64'hF800_0000);

    // Remaining base ops.
    run("or",   OR_,  32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 0, 0);
    run("and",  AND_, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 0, 0);
    run("xor",  XOR_, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 0, 0);
    run("sll",  SLL,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 0, 0);
    run("srl",  SRL,  32'h8000_0000, 32'd31,        32'h0000_0001, 0, 0);
    run("slt",  SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         0, 0);
    run("sltu", SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         0, 0);
    run("lui",  LUI,  32'h1234_5000, 32'h5555_5555, 32'h1234_5000, 0, 0);
    run("bad",  BAD,  32'd1,         32'd2,         32'd42,        0, 0);

    // Multiply: WIDTH cycles each, busy for exactly WIDTH cycles.
    run("mulhu",  MULHU,  32'h0001_0000, 32'h0001_0000, 32'd1,         W, W);
    run("mul",    MUL,    32'h0001_0000, 32'h0001_0000, 32'd0,         W, W);
    run("mulh",   MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         W, W);
    run("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, W, W);
    run("mul_neg", MUL,   32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, W, W);

    // Divide / remainder.
    run("div",  DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, W, W);
    run("rem",  REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, W, W);
    run("divu", DIVU, 32'd100,       32'd7, 32'd14,        W, W);
    run("remu", REMU, 32'd100,       32'd7, 32'd2,         W, W);

    // Fast-path special cases.
    run("div0",  DIV, 32'd5,         32'd0,         32'hFFFF_FFFF, 0, 0);
    run("rem0",  REM, 32'd5,         32'd0,         32'd5,         0, 0);
    run("divov", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
    run("remov", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0, 0);

    // Backpressure: result held, further input ignored until out_ready rises.
    step();
    bus.out_ready = 1'b0;
    issue("bp_sub", SUB, 32'd3, 32'd5);
    for (int i = 0; i < 10; i++) begin
      bus.op = ADD; bus.srcA = 32'd1; bus.srcB = 32'd1; bus.in_valid = 1'b1;
      check("bp_result", 64'(bus.result), 64'hFFFF_FFFE);
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    check("bp_next_result", 64'(bus.result), 64'd2);
    check("bp_next_valid", 64'(bus.out_valid), 64'd1);
    step();
    check("bp_consumed", 64'(bus.out_valid), 64'd0);
    check("bp_hold_after", 64'(bus.result), 64'd2);

    // Flush ten cycles into a divide, with a competing in_valid in the same cycle.
    issue("fl_div", DIVU, 32'd100, 32'd7);
    repeat (9) step();
    check("fl_busy_before", 64'(bus.busy), 64'd1);
    check("fl_in_ready_busy", 64'(bus.in_ready), 64'd0);
    @(negedge CLK);
    flush = 1'b1;
    bus.op = ADD; bus.srcA = 32'd1; bus.srcB = 32'd1; bus.in_valid = 1'b1;
    step();
    flush = 1'b0; bus.in_valid = 1'b0;
    check("fl_out_valid", 64'(bus.out_valid), 64'd0);
    check("fl_busy", 64'(bus.busy), 64'd0);
    check("fl_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    check("fl_op_dropped", 64'(bus.out_valid), 64'd0);
    run("fl_after", ADD, 32'd1, 32'd1, 32'd2, 0, 0);

    // Asynchronous reset in the middle of a multiply.
    issue("rs_mul", MULHU, 32'h0001_0000, 32'h0001_0000);
    repeat (5) step();
    check("rs_busy_before", 64'(bus.busy), 64'd1);
    #2;
    RST_N = 1'b0;
    #1;
    check("rs_out_valid", 64'(bus.out_valid), 64'd0);
    check("rs_busy", 64'(bus.busy), 64'd0);
    check("rs_in_ready", 64'(bus.in_ready), 64'd1);
    check("rs_result", 64'(bus.result), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    run("rs_after", ADD, 32'd1, 32'd1, 32'd2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
